// File: rtl/s2p_pkg.sv
// s2p_pkg: FSM states and word sizing for s2p_frame; S2P_PARITY_EN adds a trailing even-parity bit per word
package s2p_pkg;
  typedef enum logic {HUNT, SHIFT} state_t;
  function automatic int wlen(input int bits);
`ifdef S2P_PARITY_EN
    return bits + 1;
`else
    return bits;
`endif
  endfunction
  function automatic int cnt_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/s2p_lane.sv
// s2p_lane: one lane's word shift register and running parity accumulator (parity reported only with S2P_PARITY_EN)
module s2p_lane #(
  parameter int BIT       = 10,
  parameter int MSB_FIRST = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           d,
  input  logic           en,
  input  logic           first,
  input  logic           data_en,
  output logic [BIT-1:0] word,
  output logic           err
);
  logic [BIT-1:0] sr_q, sr_d;
  logic           par_q, par_d;
  always_comb begin
    sr_d  = !data_en ? sr_q : MSB_FIRST != 0 ? {sr_q[BIT-2:0], d} : {d, sr_q[BIT-1:1]};
    par_d = !en ? par_q : first ? d : par_q ^ d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      par_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      par_q <= par_d;
    end
  end
  assign word = sr_q;
`ifdef S2P_PARITY_EN
  assign err = par_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: rtl/s2p_frame.sv
// s2p_frame: multi-lane serial-to-parallel deserialiser with sof alignment and one-entry valid/ready output; S2P_PARITY_EN enables per-lane parity
module s2p_frame
  import s2p_pkg::*;
#(
  parameter int BIT       = 10,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LANES-1:0]     dext,
  input  logic                 den,
  input  logic                 sof,
  output logic [LANES*BIT-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 overflow,
  output logic [LANES-1:0]     parity_err
);
  localparam int WLEN = wlen(BIT);
  localparam int CW = cnt_w(WLEN);
  localparam logic [CW-1:0] LAST = CW'(WLEN - 1);
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, pos;
  logic                 done_q, done_d, valid_q, valid_d, ovf_q, ovf_d;
  logic                 active, first, data_en, load;
  logic [LANES*BIT-1:0] word, dout_q, dout_d;
  logic [LANES-1:0]     err, perr_q, perr_d;
  // sof with den restarts the word at bit 0 regardless of the current count
  always_comb begin
    active  = den && (sof || state_q == SHIFT);
    pos     = sof ? '0 : cnt_q;
    first   = pos == '0;
    data_en = active && int'(pos) < BIT;
    done_d  = active && pos == LAST;
    cnt_d   = !active ? cnt_q : done_d ? '0 : pos + 1'b1;
    state_d = den && sof ? SHIFT : state_q;
    load    = done_q && (!valid_q || dout_ready);
    valid_d = load || (valid_q && !dout_ready);
    ovf_d   = done_q && !load;
    dout_d  = load ? word : dout_q;
    perr_d  = load ? err : perr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
      perr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
      perr_q  <= perr_d;
    end
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    s2p_lane #(.BIT(BIT), .MSB_FIRST(MSB_FIRST)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .d      (dext[k]),
      .en     (active),
      .first  (first),
      .data_en(data_en),
      .word   (word[k*BIT +: BIT]),
      .err    (err[k])
    );
  end
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overflow   = ovf_q;
  assign parity_err = perr_q;
endmodule
